instr_loader: RTL and testbench

- Upstream feeder of the fetch stage's instruction memory.
- Accepts a byte stream from the UART receiver over a valid/ready handshake and packs each 4 bytes into a 32-bit instruction, MSB first.
- Drives the instruction word, byte address, loading level and write strobe into fetch, with sequential addresses starting at 0.
- Stops on the HALT word, then flags completion so the pipeline can be released from reset/loading.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/instr_loader_if.sv | 20 ++
 rtl/instr_loader_packer.sv | 42 ++++
 rtl/instr_loader.sv | 159 +++++++++++++++
 tb/tb_instr_loader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction loader.
// The LOADER_CHECKSUM_EN build reaches S_CHK; otherwise it is never entered.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BYTE_WIDTH = 8;
    localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;

    function automatic int bytes_per_word(input int dw, input int bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte stream valid/ready channel from the UART receiver into the loader.
interface instr_loader_if #(
    parameter int BYTE_WIDTH = 8
);
    logic [BYTE_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/instr_loader_packer.sv
// byte_packer: MSB-first shift register with a byte counter; pulses
// o_word_valid for one cycle after the last byte of a word is taken.
module byte_packer
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_shift,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_last,
    output logic                  o_word_valid
);
    localparam int BPW = bytes_per_word(DATA_WIDTH, BYTE_WIDTH);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_valid;

    assign o_last       = i_shift && (r_cnt == CW'(BPW - 1));
    assign o_word       = r_word;
    assign o_word_valid = r_valid;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_cnt   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= o_last;
            if (i_shift) begin
                r_word <= {r_word[DATA_WIDTH-BYTE_WIDTH-1:0], i_byte};
                r_cnt  <= o_last ? '0 : r_cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/instr_loader.sv
// Packs a UART byte stream into instruction words for fetch memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR check byte after HALT.
module instr_loader
    import loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    instr_loader_if.slave                rx,
    output logic [DATA_WIDTH-1:0]        o_instruccion,
    output logic [DATA_WIDTH-1:0]        o_address,
    output logic                         o_loading,
    output logic                         o_write,
    output logic                         o_done,
    output logic                         o_overflow,
    output logic                         o_chk_error,
    output logic [$clog2(MEM_DEPTH):0]   o_word_count
);
    localparam int IW = $clog2(MEM_DEPTH) + 1;

    state_t r_state, w_next;

    logic [IW-1:0]         r_index;
    logic [IW-1:0]         w_idx_inc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_addr_now;
    logic                  r_ovf;
    logic                  w_last;
    logic                  w_word_valid;
    logic                  w_accept;
    logic                  w_start_ok;
    logic                  w_is_halt;
    logic                  w_full;

    assign w_accept   = rx.rx_valid && (r_state == S_RECV);
    assign w_start_ok = i_start && (r_state == S_IDLE ||
                                    r_state == S_DONE ||
                                    r_state == S_ERR);
    assign w_idx_inc  = r_index + IW'(1);
    assign w_full     = (w_idx_inc == IW'(MEM_DEPTH));
    assign w_is_halt  = (w_word == HALT_WORD);
    assign w_addr_now = DATA_WIDTH'(r_index) << 2;

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_packer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (w_start_ok),
        .i_shift      (w_accept),
        .i_byte       (rx.rx_data),
        .o_word       (w_word),
        .o_last       (w_last),
        .o_word_valid (w_word_valid)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] r_csum;
    logic                  r_chk_err;
    logic                  w_chk_take;
    logic                  w_chk_ok;

    assign w_chk_take = rx.rx_valid && (r_state == S_CHK);
    assign w_chk_ok   = (rx.rx_data == r_csum);

    always_ff @(posedge i_clock) begin
        if (i_reset || w_start_ok) begin
            r_csum    <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_accept)
                r_csum <= r_csum ^ rx.rx_data;
            if (w_chk_take && !w_chk_ok)
                r_chk_err <= 1'b1;
        end
    end

    assign o_chk_error = r_chk_err;
`else
    assign o_chk_error = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start)
                    w_next = S_RECV;
            end
            S_RECV: begin
                if (w_last)
                    w_next = S_WRITE;
            end
            S_WRITE: begin
                if (w_is_halt)
`ifdef LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                else if (w_full)
                    w_next = S_ERR;
                else
                    w_next = S_RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_chk_take)
                    w_next = w_chk_ok ? S_DONE : S_ERR;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Output word/address hold their last written values between writes.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_index <= '0;
            r_instr <= '0;
            r_addr  <= '0;
            r_ovf   <= 1'b0;
        end else if (w_start_ok) begin
            r_index <= '0;
            r_ovf   <= 1'b0;
        end else if (r_state == S_WRITE) begin
            r_index <= w_idx_inc;
            r_instr <= w_word;
            r_addr  <= w_addr_now;
            if (!w_is_halt && w_full)
                r_ovf <= 1'b1;
        end
    end

    assign rx.rx_ready    = (r_state == S_RECV) || (r_state == S_CHK);
    assign o_write        = w_word_valid;
    assign o_instruccion  = (r_state == S_WRITE) ? w_word : r_instr;
    assign o_address      = (r_state == S_WRITE) ? w_addr_now : r_addr;
    assign o_loading      = (r_state == S_RECV) || (r_state == S_WRITE) ||
                            (r_state == S_CHK);
    assign o_done         = (r_state == S_DONE);
    assign o_overflow     = r_ovf;
    assign o_word_count   = r_index;
endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a 256-word DUT and a 4-word DUT.
// Build with LOADER_CHECKSUM_EN defined to also cover the check byte.
module tb_instr_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_start = 1'b0;
    logic [7:0] tb_data = '0;
    logic tb_valid = 1'b0;
    logic sel = 1'b0;

    int checks = 0;
    int failures = 0;
    int exp_idx = 0;
    logic [7:0] exp_csum = '0;

    logic [63:0] qm[$];
    logic [63:0] qs[$];

    always #5 clk = ~clk;

    instr_loader_if #(.BYTE_WIDTH(8)) m_if ();
    instr_loader_if #(.BYTE_WIDTH(8)) s_if ();

    assign m_if.rx_data  = tb_data;
    assign m_if.rx_valid = tb_valid && !sel;
    assign s_if.rx_data  = tb_data;
    assign s_if.rx_valid = tb_valid && sel;

    logic m_start, s_start;
    assign m_start = tb_start && !sel;
    assign s_start = tb_start && sel;

    logic [31:0] m_instr, m_addr, s_instr, s_addr;
    logic m_load, m_write, m_done, m_ovf, m_cerr;
    logic s_load, s_write, s_done, s_ovf, s_cerr;
    logic [8:0] m_cnt;
    logic [2:0] s_cnt;

    instr_loader #(.MEM_DEPTH(256)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (m_start),
        .rx            (m_if.slave),
        .o_instruccion (m_instr),
        .o_address     (m_addr),
        .o_loading     (m_load),
        .o_write       (m_write),
        .o_done        (m_done),
        .o_overflow    (m_ovf),
        .o_chk_error   (m_cerr),
        .o_word_count  (m_cnt)
    );

    instr_loader #(.MEM_DEPTH(4)) dut_s (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (s_start),
        .rx            (s_if.slave),
        .o_instruccion (s_instr),
        .o_address     (s_addr),
        .o_loading     (s_load),
        .o_write       (s_write),
        .o_done        (s_done),
        .o_overflow    (s_ovf),
        .o_chk_error   (s_cerr),
        .o_word_count  (s_cnt)
    );

    logic w_ready, w_write, w_done, w_ovf, w_load, w_cerr;
    logic [31:0] w_cnt;
    assign w_ready = sel ? s_if.rx_ready : m_if.rx_ready;
    assign w_write = sel ? s_write : m_write;
    assign w_done  = sel ? s_done : m_done;
    assign w_ovf   = sel ? s_ovf : m_ovf;
    assign w_load  = sel ? s_load : m_load;
    assign w_cerr  = sel ? s_cerr : m_cerr;
    assign w_cnt   = sel ? 32'(s_cnt) : 32'(m_cnt);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop one expected write per strobe.
    always @(negedge clk) begin
        logic [63:0] e;
        if (m_write === 1'b1) begin
            if (qm.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m_unexpected_write actual=%h@%h required=none",
                         m_instr, m_addr);
            end else begin
                e = qm.pop_front();
                chk("m_write_addr", m_addr, e[63:32]);
                chk("m_write_data", m_instr, e[31:0]);
            end
        end
        if (m_load === 1'b1)
            chk("m_ready_vs_write", 32'(m_if.rx_ready), 32'(!m_write));
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (s_write === 1'b1) begin
            if (qs.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL s_unexpected_write actual=%h@%h required=none",
                         s_instr, s_addr);
            end else begin
                e = qs.pop_front();
                chk("s_write_addr", s_addr, e[63:32]);
                chk("s_write_data", s_instr, e[31:0]);
            end
        end
        if (s_load === 1'b1)
            chk("s_ready_vs_write", 32'(s_if.rx_ready), 32'(!s_write));
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        tb_data  = b;
        tb_valid = 1'b1;
        while (!w_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input int pulse_at);
        logic [63:0] e;
        e = {32'(exp_idx * 4), w};
        if (sel) qs.push_back(e);
        else qm.push_back(e);
        exp_idx++;
        for (int i = 0; i < 4; i++) begin
            exp_csum = exp_csum ^ w[31-8*i -: 8];
            if (i == pulse_at) tb_start = 1'b1;
            send_byte(w[31-8*i -: 8]);
            tb_start = 1'b0;
        end
        @(negedge clk);
        chk("write_latency", 32'(w_write), 32'd1);
    endtask

    task automatic do_start();
        @(negedge clk);
        tb_valid = 1'b0;
        tb_start = 1'b1;
        @(posedge clk);
        #1;
        tb_start = 1'b0;
        exp_idx  = 0;
        exp_csum = '0;
        @(negedge clk);
        chk("start_loading", 32'(w_load), 32'd1);
        chk("start_done", 32'(w_done), 32'd0);
        chk("start_ovf", 32'(w_ovf), 32'd0);
        chk("start_cnt", w_cnt, 32'd0);
    endtask

    task automatic end_load_ok(input int cnt);
`ifdef LOADER_CHECKSUM_EN
        send_byte(exp_csum);
`endif
        tb_valid = 1'b0;
        @(negedge clk);
        chk("end_done", 32'(w_done), 32'd1);
        chk("end_loading", 32'(w_load), 32'd0);
        chk("end_ovf", 32'(w_ovf), 32'd0);
        chk("end_chk_err", 32'(w_cerr), 32'd0);
        chk("end_cnt", w_cnt, 32'(cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_write", 32'(m_write), 32'd0);
        chk("rst_loading", 32'(m_load), 32'd0);
        chk("rst_done", 32'(m_done), 32'd0);
        chk("rst_ready", 32'(m_if.rx_ready), 32'd0);
        chk("rst_instr", m_instr, 32'd0);
        chk("rst_addr", m_addr, 32'd0);
        chk("rst_cnt", 32'(m_cnt), 32'd0);
        chk("rst_s_ovf", 32'(s_ovf), 32'd0);

        // Basic two-word load ending in HALT.
        do_start();
        send_word(32'h2001_0005, -1);
        send_word(32'hFFFF_FFFF, -1);
        end_load_ok(2);

        // Back-to-back words with valid held high throughout.
        do_start();
        send_word(32'h1122_3344, -1);
        send_word(32'hA5A5_5A5A, -1);
        send_word(32'h0000_0000, -1);
        send_word(32'hFFFF_FFFF, -1);
        end_load_ok(4);

        // Start pulse mid-word is ignored.
        do_start();
        send_word(32'h0102_0304, -1);
        send_word(32'hDEAD_BEEF, 2);
        send_word(32'hFFFF_FFFF, 1);
        end_load_ok(3);

        // Reset after two bytes abandons the partial word.
        do_start();
        send_byte(8'hAA);
        send_byte(8'hBB);
        tb_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_write", 32'(m_write), 32'd0);
        chk("midrst_instr", m_instr, 32'd0);
        chk("midrst_addr", m_addr, 32'd0);
        chk("midrst_loading", 32'(m_load), 32'd0);
        chk("midrst_ready", 32'(m_if.rx_ready), 32'd0);
        chk("midrst_cnt", 32'(m_cnt), 32'd0);
        do_start();
        send_word(32'hCAFE_F00D, -1);
        send_word(32'hFFFF_FFFF, -1);
        end_load_ok(2);

        // Small-depth instance: overflow then restart.
        sel = 1'b1;
        do_start();
        send_word(32'h1000_0001, -1);
        send_word(32'h1000_0002, -1);
        send_word(32'h1000_0003, -1);
        send_word(32'h1000_0004, -1);
        tb_data  = 8'h77;
        tb_valid = 1'b1;
        repeat (5) @(negedge clk);
        tb_valid = 1'b0;
        chk("ovf_flag", 32'(w_ovf), 32'd1);
        chk("ovf_loading", 32'(w_load), 32'd0);
        chk("ovf_done", 32'(w_done), 32'd0);
        chk("ovf_ready", 32'(w_ready), 32'd0);
        chk("ovf_cnt", w_cnt, 32'd4);
        do_start();
        send_word(32'hFFFF_FFFF, -1);
        end_load_ok(1);

        // HALT at the last legal index completes rather than overflows.
        do_start();
        send_word(32'h2000_0001, -1);
        send_word(32'h2000_0002, -1);
        send_word(32'h2000_0003, -1);
        send_word(32'hFFFF_FFFF, -1);
        end_load_ok(4);
        sel = 1'b0;

`ifdef LOADER_CHECKSUM_EN
        do_start();
        send_word(32'hFFFF_FFFF, -1);
        send_byte(8'h00);
        tb_valid = 1'b0;
        @(negedge clk);
        chk("cs_ok_done", 32'(m_done), 32'd1);
        chk("cs_ok_err", 32'(m_cerr), 32'd0);
        do_start();
        send_word(32'hFFFF_FFFF, -1);
        send_byte(8'h5A);
        tb_valid = 1'b0;
        @(negedge clk);
        chk("cs_bad_err", 32'(m_cerr), 32'd1);
        chk("cs_bad_done", 32'(m_done), 32'd0);
        chk("cs_bad_loading", 32'(m_load), 32'd0);
        chk("cs_bad_ovf", 32'(m_ovf), 32'd0);
`endif

        repeat (2) @(negedge clk);
        chk("qm_empty", 32'(qm.size()), 32'd0);
        chk("qs_empty", 32'(qs.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
